// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/LS destination state to drive ID forwarding,
// load-use bubbles, memory-wait freeze, taken-jump flush and stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_cen_i,
  input  logic             id_rs2_cen_i,
  input  logic             id_rd_wen_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic             id_mem_read_i,
  input  logic             id_mem_write_i,
  input  logic             id_jump_i,
  input  logic             lsu_ready_i,
  output logic             forward_ex_rs1_o,
  output logic             forward_ex_rs2_o,
  output logic             forward_ls_rs1_o,
  output logic             forward_ls_rs2_o,
  output logic             ex_ls_mem_read_o,
  output logic             stall_pc_o,
  output logic             stall_ifid_o,
  output logic             bubble_ex_o,
  output logic             freeze_o,
  output logic             flush_ifid_o,
  output logic             jump_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic       wen;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
  } shadow_t;

  shadow_t          ex_q, ex_d, ls_q, ls_d;
  logic             run_q, run_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic rs1_live, rs2_live;
  logic match_ex_1, match_ex_2, match_ls_1, match_ls_2;
  logic mem_wait, load_use;

  // A source only counts when ID really reads a non-x0 register after the run bit is set.
  assign rs1_live = run_q & id_valid_i & id_rs1_cen_i & (id_rs1_addr_i != 5'd0);
  assign rs2_live = run_q & id_valid_i & id_rs2_cen_i & (id_rs2_addr_i != 5'd0);

  assign match_ex_1 = rs1_live & ex_q.valid & ex_q.wen & (ex_q.rd == id_rs1_addr_i);
  assign match_ex_2 = rs2_live & ex_q.valid & ex_q.wen & (ex_q.rd == id_rs2_addr_i);
  assign match_ls_1 = rs1_live & ls_q.valid & ls_q.wen & (ls_q.rd == id_rs1_addr_i);
  assign match_ls_2 = rs2_live & ls_q.valid & ls_q.wen & (ls_q.rd == id_rs2_addr_i);

  assign mem_wait = run_q & ls_q.valid & (ls_q.mem_read | ls_q.mem_write) & ~lsu_ready_i;
  assign load_use = (match_ex_1 | match_ex_2) & ex_q.mem_read & ~mem_wait;

  assign forward_ex_rs1_o = match_ex_1 & ~ex_q.mem_read;
  assign forward_ex_rs2_o = match_ex_2 & ~ex_q.mem_read;
  assign forward_ls_rs1_o = match_ls_1 & ~match_ex_1;
  assign forward_ls_rs2_o = match_ls_2 & ~match_ex_2;
  assign ex_ls_mem_read_o = ls_q.valid & ls_q.mem_read;

  assign freeze_o     = mem_wait;
  assign stall_pc_o   = load_use | mem_wait;
  assign stall_ifid_o = load_use | mem_wait;
  assign bubble_ex_o  = load_use;
  assign jump_en_o    = run_q & id_valid_i & id_jump_i & ~load_use & ~mem_wait;
  assign flush_ifid_o = jump_en_o;

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_comb begin
    run_d       = 1'b1;
    ex_d        = ex_q;
    ls_d        = ls_q;
    stall_cnt_d = stall_cnt_q + CNT_W'(stall_pc_o);
    flush_cnt_d = flush_cnt_q + CNT_W'(flush_ifid_o);
    if (!mem_wait) begin
      ls_d = ex_q;
      if (load_use) begin
        ex_d = '0;
      end else begin
        ex_d = {id_valid_i, id_rd_wen_i, id_rd_addr_i, id_mem_read_i, id_mem_write_i};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      ex_q        <= '0;
      ls_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      run_q       <= run_d;
      ex_q        <= ex_d;
      ls_q        <= ls_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a pipeline-slot reference model,
// plus directed reset-release and reset-during-load-use sequences.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid_i, id_rs1_cen_i, id_rs2_cen_i, id_rd_wen_i;
  logic [4:0]    id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic          id_mem_read_i, id_mem_write_i, id_jump_i, lsu_ready_i;
  logic          forward_ex_rs1_o, forward_ex_rs2_o, forward_ls_rs1_o, forward_ls_rs2_o;
  logic          ex_ls_mem_read_o, stall_pc_o, stall_ifid_o, bubble_ex_o;
  logic          freeze_o, flush_ifid_o, jump_en_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: slot 0 is the instruction in EX, slot 1 the one in LS.
  bit         m_run;
  bit         s_valid [2];
  bit         s_wen   [2];
  logic [4:0] s_rd    [2];
  bit         s_load  [2];
  bit         s_store [2];
  logic [CW-1:0] m_stalls, m_flushes;

  bit e_fex [2];
  bit e_fls [2];
  bit e_lsmr, e_wait, e_lu, e_jump;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_cen_i(id_rs1_cen_i), .id_rs2_cen_i(id_rs2_cen_i),
    .id_rd_wen_i(id_rd_wen_i), .id_rd_addr_i(id_rd_addr_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_jump_i(id_jump_i), .lsu_ready_i(lsu_ready_i),
    .forward_ex_rs1_o(forward_ex_rs1_o), .forward_ex_rs2_o(forward_ex_rs2_o),
    .forward_ls_rs1_o(forward_ls_rs1_o), .forward_ls_rs2_o(forward_ls_rs2_o),
    .ex_ls_mem_read_o(ex_ls_mem_read_o),
    .stall_pc_o(stall_pc_o), .stall_ifid_o(stall_ifid_o),
    .bubble_ex_o(bubble_ex_o), .freeze_o(freeze_o),
    .flush_ifid_o(flush_ifid_o), .jump_en_o(jump_en_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_run = 0;
    m_stalls = '0;
    m_flushes = '0;
    for (int s = 0; s < 2; s++) begin
      s_valid[s] = 0; s_wen[s] = 0; s_rd[s] = '0; s_load[s] = 0; s_store[s] = 0;
    end
  endtask

  // Does slot s produce register r for a live read in ID?
  function automatic bit produces(int s, logic [4:0] r, bit cen);
    return m_run && id_valid_i && cen && (r != 5'd0) && s_valid[s] && s_wen[s] && (s_rd[s] == r);
  endfunction

  task automatic compute_expected();
    logic [4:0] src [2];
    bit cen [2];
    bit hit_ex [2];
    src[0] = id_rs1_addr_i; src[1] = id_rs2_addr_i;
    cen[0] = id_rs1_cen_i;  cen[1] = id_rs2_cen_i;
    e_wait = m_run && s_valid[1] && (s_load[1] || s_store[1]) && !lsu_ready_i;
    for (int n = 0; n < 2; n++) begin
      hit_ex[n] = produces(0, src[n], cen[n]);
      e_fex[n]  = hit_ex[n] && !s_load[0];
      e_fls[n]  = produces(1, src[n], cen[n]) && !hit_ex[n];
    end
    e_lu   = (hit_ex[0] || hit_ex[1]) && s_load[0] && !e_wait;
    e_lsmr = s_valid[1] && s_load[1];
    e_jump = m_run && id_valid_i && id_jump_i && !e_lu && !e_wait;
  endtask

  task automatic check_now();
    compute_expected();
    checkOutput("fwd_ex_rs1", forward_ex_rs1_o, e_fex[0]);
    checkOutput("fwd_ex_rs2", forward_ex_rs2_o, e_fex[1]);
    checkOutput("fwd_ls_rs1", forward_ls_rs1_o, e_fls[0]);
    checkOutput("fwd_ls_rs2", forward_ls_rs2_o, e_fls[1]);
    checkOutput("ex_ls_mem_read", ex_ls_mem_read_o, e_lsmr);
    checkOutput("stall_pc", stall_pc_o, e_lu || e_wait);
    checkOutput("stall_ifid", stall_ifid_o, e_lu || e_wait);
    checkOutput("bubble_ex", bubble_ex_o, e_lu);
    checkOutput("freeze", freeze_o, e_wait);
    checkOutput("jump_en", jump_en_o, e_jump);
    checkOutput("flush_ifid", flush_ifid_o, e_jump);
    checkOutput("stall_cnt", stall_cnt_o, m_stalls);
    checkOutput("flush_cnt", flush_cnt_o, m_flushes);
  endtask

  // Clock edge: the pipeline advances unless LS is still waiting on memory.
  task automatic advance();
    compute_expected();
    @(posedge clk);
    if (rst_n) begin
      m_stalls  = m_stalls + CW'(e_lu || e_wait);
      m_flushes = m_flushes + CW'(e_jump);
      if (!e_wait) begin
        s_valid[1] = s_valid[0]; s_wen[1] = s_wen[0]; s_rd[1] = s_rd[0];
        s_load[1]  = s_load[0];  s_store[1] = s_store[0];
        if (e_lu) begin
          s_valid[0] = 0; s_wen[0] = 0; s_rd[0] = '0; s_load[0] = 0; s_store[0] = 0;
        end else begin
          s_valid[0] = id_valid_i; s_wen[0] = id_rd_wen_i; s_rd[0] = id_rd_addr_i;
          s_load[0]  = id_mem_read_i; s_store[0] = id_mem_write_i;
        end
      end
      m_run = 1;
    end
    #1;
  endtask

  task automatic applyStimulus();
    id_valid_i     = ($urandom_range(0, 9) != 0);
    id_rs1_addr_i  = 5'($urandom_range(0, 3));
    id_rs2_addr_i  = 5'($urandom_range(0, 3));
    id_rs1_cen_i   = ($urandom_range(0, 4) != 0);
    id_rs2_cen_i   = ($urandom_range(0, 4) != 0);
    id_rd_wen_i    = ($urandom_range(0, 3) != 0);
    id_rd_addr_i   = 5'($urandom_range(0, 3));
    id_mem_read_i  = ($urandom_range(0, 2) == 0);
    id_mem_write_i = !id_mem_read_i && ($urandom_range(0, 4) == 0);
    id_jump_i      = ($urandom_range(0, 2) == 0);
    lsu_ready_i    = ($urandom_range(0, 2) != 0);
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs1, input bit c1, input logic [4:0] rs2,
                        input bit c2, input bit wen, input logic [4:0] rd, input bit ld, input bit jmp);
    id_valid_i = v; id_rs1_addr_i = rs1; id_rs1_cen_i = c1;
    id_rs2_addr_i = rs2; id_rs2_cen_i = c2; id_rd_wen_i = wen; id_rd_addr_i = rd;
    id_mem_read_i = ld; id_mem_write_i = 0; id_jump_i = jmp; lsu_ready_i = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    set_id(1, 5'd1, 1, 5'd2, 1, 1, 5'd1, 1, 1);
    #2 check_now();
    // Release between edges: outputs must stay 0 until the first edge sets the run bit.
    #5 rst_n = 1'b1;
    #1 check_now();
    checkOutput("pre_run_jump_en", jump_en_o, 0);
    advance();

    for (int cyc = 0; cyc < 600; cyc++) begin
      applyStimulus();
      @(negedge clk);
      check_now();
      advance();
    end

    // Load into x6, then a branch reading x6 in ID: load-use stall, then reset mid-stall.
    set_id(1, 5'd0, 0, 5'd0, 0, 1, 5'd6, 1, 0);
    @(negedge clk);
    check_now();
    advance();
    set_id(1, 5'd0, 0, 5'd6, 1, 0, 5'd0, 0, 1);
    @(negedge clk);
    check_now();
    checkOutput("load_use_bubble", bubble_ex_o, 1);
    checkOutput("load_use_jump_en", jump_en_o, 0);
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_now();
    checkOutput("reset_stall_pc", stall_pc_o, 0);
    checkOutput("reset_stall_cnt", stall_cnt_o, 0);
    advance();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_now();
    advance();
    for (int cyc = 0; cyc < 50; cyc++) begin
      applyStimulus();
      @(negedge clk);
      check_now();
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
